// File: rtl/synth_pkg.sv
// Shared constants and types for the synth chain sequencer blocks.
package synth_pkg;

    localparam int unsigned STEPS       = 16;
    localparam int unsigned NVOICES     = 4;
    localparam int unsigned NOTEBITS    = 7;
    localparam int unsigned SAMPLE_RATE = 31250;

    typedef struct packed {
        logic                valid;
        logic [NOTEBITS-1:0] note;
    } pattern_entry_t;

    typedef enum logic [1:0] {
        VOICE_OFF,
        VOICE_ON,
        VOICE_GAP
    } voice_state_t;

    typedef enum logic {
        SEQ_STOPPED,
        SEQ_RUNNING
    } seq_state_t;

endpackage

// File: rtl/seq_gate_ctrl.sv
// Per-voice gate FSM: OFF/ON/GAP with a gate-length counter in sample ticks.
module seq_gate_ctrl
    import synth_pkg::*;
#(
    parameter int unsigned GATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_tick,
    input  logic              clear,
    input  logic              trigger,
    input  logic [GATE_W-1:0] gate_len,
    output logic              gate
);

    voice_state_t      state_q, state_d;
    logic [GATE_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VOICE_OFF;
            cnt_q   <= '0;
            gate    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate    <= (state_d == VOICE_ON);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = VOICE_OFF;
            cnt_d   = '0;
        end else if (trigger) begin
            if (gate_len == '0) begin
                state_d = VOICE_OFF;
                cnt_d   = '0;
            end else if (state_q == VOICE_OFF) begin
                state_d = VOICE_ON;
                cnt_d   = gate_len;
            end else begin
                // Retrigger: hold the gate low for one tick so envelopes restart
                state_d = VOICE_GAP;
            end
        end else if (sample_tick) begin
            case (state_q)
                VOICE_ON: begin
                    if (cnt_q <= GATE_W'(1)) begin
                        state_d = VOICE_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                VOICE_GAP: begin
                    if (gate_len == '0) begin
                        state_d = VOICE_OFF;
                        cnt_d   = '0;
                    end else begin
                        state_d = VOICE_ON;
                        cnt_d   = gate_len;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Pattern-driven note/gate scheduler: a STEPS x NVOICES pattern stepped every
// tempo_div sample ticks, driving per-voice notes and gate pulses.
module step_sequencer
    import synth_pkg::*;
#(
    parameter int unsigned NVOICES  = synth_pkg::NVOICES,
    parameter int unsigned STEPS    = synth_pkg::STEPS,
    parameter int unsigned NOTEBITS = synth_pkg::NOTEBITS,
    parameter int unsigned TEMPO_W  = 16,
    parameter int unsigned GATE_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          run,
    input  logic [TEMPO_W-1:0]            tempo_div,
    input  logic [GATE_W-1:0]             gate_len,
    input  logic                          wr_en,
    input  logic [$clog2(STEPS)-1:0]      wr_step,
    input  logic [$clog2(NVOICES)-1:0]    wr_voice,
    input  logic [NOTEBITS:0]             wr_data,
    output logic [NVOICES-1:0]            gate,
    output logic [NVOICES*NOTEBITS-1:0]   note,
    output logic [$clog2(STEPS)-1:0]      step,
    output logic                          step_strobe
);

    localparam int unsigned STEP_W = $clog2(STEPS);

    seq_state_t         state_q, state_d;
    logic               first_q;
    logic [TEMPO_W-1:0] tick_cnt_q;
    logic [TEMPO_W-1:0] tick_limit;
    logic               fire;
    logic               stop;
    logic [STEP_W-1:0]  fire_step;
    logic [NOTEBITS:0]  pat_mem [STEPS][NVOICES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEQ_STOPPED;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fire       = 1'b0;
        stop       = 1'b0;
        fire_step  = step + 1'b1;
        tick_limit = (tempo_div == '0) ? '0 : tempo_div - 1'b1;
        case (state_q)
            SEQ_STOPPED: begin
                if (run) state_d = SEQ_RUNNING;
            end
            SEQ_RUNNING: begin
                if (!run) begin
                    state_d = SEQ_STOPPED;
                    stop    = 1'b1;
                end else if (sample_tick) begin
                    if (first_q) begin
                        fire      = 1'b1;
                        fire_step = '0;
                    end else if (tick_cnt_q >= tick_limit) begin
                        // >= so a shortened tempo fires on the next tick
                        fire = 1'b1;
                    end
                end
            end
            default: state_d = SEQ_STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q     <= 1'b1;
            tick_cnt_q  <= '0;
            step        <= '0;
            step_strobe <= 1'b0;
        end else begin
            step_strobe <= fire;
            if (stop || state_q == SEQ_STOPPED) begin
                first_q    <= 1'b1;
                tick_cnt_q <= '0;
                if (stop) step <= '0;
            end else if (fire) begin
                first_q    <= 1'b0;
                tick_cnt_q <= '0;
                step       <= fire_step;
            end else if (sample_tick && !first_q) begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
        end
    end

    // Fire reads pat_mem combinationally, so a same-cycle write is seen next pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_mem <= '{default: '0};
        end else if (wr_en) begin
            pat_mem[wr_step][wr_voice] <= wr_data;
        end
    end

    for (genvar v = 0; v < NVOICES; v++) begin : g_voice
        logic [NOTEBITS:0]   entry;
        logic                trigger;
        logic [NOTEBITS-1:0] note_q;

        assign entry   = pat_mem[fire_step][v];
        assign trigger = fire && entry[NOTEBITS];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       note_q <= '0;
            else if (trigger) note_q <= entry[NOTEBITS-1:0];
        end

        assign note[v*NOTEBITS +: NOTEBITS] = note_q;

        seq_gate_ctrl #(
            .GATE_W (GATE_W)
        ) u_gate (
            .clk         (clk),
            .rst_n       (rst_n),
            .sample_tick (sample_tick),
            .clear       (stop),
            .trigger     (trigger),
            .gate_len    (gate_len),
            .gate        (gate[v])
        );
    end

endmodule
